// File: rtl/i2c_reg_bank.sv
// i2c_reg_bank: application-side register bank for the I2C peripheral.
// Holds CFG0..CFG7, an ID constant, a synchronised status input, W1C
// interrupt flags with a mask, and a saturating write counter.
module i2c_reg_bank #(
  parameter logic [7:0]  ID_VALUE  = 8'hA5,
  parameter logic [63:0] CFG_RESET = 64'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  addr,
  input  logic [7:0]  wdata,
  input  logic        we,
  output logic [7:0]  rdata,
  output logic [7:0]  status_o,
  input  logic [7:0]  status_i,
  input  logic [7:0]  event_i,
  output logic [63:0] cfg_o,
  output logic        irq_o
);

  localparam logic [7:0] ADDR_STATUS = 8'h08;
  localparam logic [7:0] ADDR_FLAGS  = 8'h09;
  localparam logic [7:0] ADDR_MASK   = 8'h0A;
  localparam logic [7:0] ADDR_WRCNT  = 8'h0B;
  localparam logic [7:0] ADDR_ID     = 8'h0C;

  logic [63:0] cfg_q, cfg_d;
  logic [7:0]  flags_q, flags_d;
  logic [7:0]  mask_q, mask_d;
  logic [7:0]  wrcnt_q, wrcnt_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        irq_q, irq_d;
  logic [7:0]  stat_meta_q, stat_sync_q;
  logic [7:0]  event_q;
  logic [7:0]  set_vec, clr_vec;

  // Edge detect on events and W1C clear vector from the write path
  always_comb begin
    set_vec = event_i & ~event_q;
    clr_vec = (we && addr == ADDR_FLAGS) ? wdata : '0;
  end

  // Next-state for writable registers, flags and the write counter
  always_comb begin
    cfg_d   = cfg_q;
    mask_d  = mask_q;
    wrcnt_d = wrcnt_q;
    // Set is applied after clear so a same-cycle rise keeps the flag.
    flags_d = (flags_q & ~clr_vec) | set_vec;
    if (we) begin
      if (addr < 8'h08) begin
        cfg_d[{addr[2:0], 3'b000} +: 8] = wdata;
      end
      if (addr == ADDR_MASK) begin
        mask_d = wdata;
      end
      if (addr == ADDR_WRCNT) begin
        wrcnt_d = '0;
      end else if (wrcnt_q != '1) begin
        wrcnt_d = wrcnt_q + 8'd1;
      end
    end
  end

  // Read mux on pre-write register values
  always_comb begin
    rdata_d = '0;
    if (addr < 8'h08) begin
      rdata_d = cfg_q[{addr[2:0], 3'b000} +: 8];
    end else begin
      case (addr)
        ADDR_STATUS: rdata_d = stat_sync_q;
        ADDR_FLAGS:  rdata_d = flags_q;
        ADDR_MASK:   rdata_d = mask_q;
        ADDR_WRCNT:  rdata_d = wrcnt_q;
        ADDR_ID:     rdata_d = ID_VALUE;
        default:     rdata_d = '0;
      endcase
    end
  end

  // Interrupt from registered flags and mask, so it lags by one cycle
  always_comb begin
    irq_d = |(flags_q & mask_q);
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q       <= CFG_RESET;
      flags_q     <= '0;
      mask_q      <= '0;
      wrcnt_q     <= '0;
      rdata_q     <= '0;
      irq_q       <= 1'b0;
      stat_meta_q <= '0;
      stat_sync_q <= '0;
      event_q     <= '0;
    end else begin
      cfg_q       <= cfg_d;
      flags_q     <= flags_d;
      mask_q      <= mask_d;
      wrcnt_q     <= wrcnt_d;
      rdata_q     <= rdata_d;
      irq_q       <= irq_d;
      stat_meta_q <= status_i;
      stat_sync_q <= stat_meta_q;
      event_q     <= event_i;
    end
  end

  assign cfg_o    = cfg_q;
  assign rdata    = rdata_q;
  assign status_o = flags_q;
  assign irq_o    = irq_q;

endmodule

// File: tb/tb_i2c_reg_bank.sv
// Directed testbench for i2c_reg_bank; inputs change and outputs are
// sampled on the falling clock edge.
module tb_i2c_reg_bank;

  logic        clk;
  logic        rst_n;
  logic [7:0]  addr;
  logic [7:0]  wdata;
  logic        we;
  logic [7:0]  rdata;
  logic [7:0]  status_o;
  logic [7:0]  status_i;
  logic [7:0]  event_i;
  logic [63:0] cfg_o;
  logic        irq_o;

  int unsigned n_run;
  int unsigned n_fail;

  i2c_reg_bank #(
    .ID_VALUE  (8'hA5),
    .CFG_RESET (64'h0)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .addr     (addr),
    .wdata    (wdata),
    .we       (we),
    .rdata    (rdata),
    .status_o (status_o),
    .status_i (status_i),
    .event_i  (event_i),
    .cfg_o    (cfg_o),
    .irq_o    (irq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle write strobe; returns on the following falling edge
  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    @(negedge clk);
    we    = 1'b0;
  endtask

  // Present an address and sample rdata one cycle later
  task automatic rd(input string tag, input logic [7:0] a, input logic [7:0] exp);
    addr = a;
    idle(1);
    chk(tag, {56'h0, rdata}, {56'h0, exp});
  endtask

  initial begin
    n_run    = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    addr     = '0;
    wdata    = '0;
    we       = 1'b0;
    status_i = '0;
    event_i  = '0;

    // Reset state
    #12;
    chk("rst_cfg",    cfg_o,           64'h0);
    chk("rst_rdata",  {56'h0, rdata},  64'h0);
    chk("rst_irq",    {63'h0, irq_o},  64'h0);
    chk("rst_status", {56'h0, status_o}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);

    rd("id_read", 8'h0C, 8'hA5);

    // CFG write, readback and counter
    wr(8'h03, 8'h5C);
    chk("cfg3_out", cfg_o, 64'h0000_0000_5C00_0000);
    rd("cfg3_read", 8'h03, 8'h5C);
    rd("wrcnt_1",   8'h0B, 8'h01);

    // Masked event raises the interrupt one cycle after the flag
    wr(8'h0A, 8'h04);
    event_i = 8'h04;
    idle(1);
    chk("flag2_set", {56'h0, status_o}, 64'h04);
    chk("irq_lag",   {63'h0, irq_o},    64'h0);
    idle(1);
    chk("irq_on",    {63'h0, irq_o},    64'h1);
    wr(8'h09, 8'h04);
    chk("flag2_clr", {56'h0, status_o}, 64'h0);
    chk("irq_still", {63'h0, irq_o},    64'h1);
    idle(1);
    chk("irq_off",   {63'h0, irq_o},    64'h0);
    event_i = 8'h00;

    // Set wins over a same-cycle W1C clear
    @(negedge clk);
    addr    = 8'h09;
    wdata   = 8'h01;
    we      = 1'b1;
    event_i = 8'h01;
    @(negedge clk);
    we = 1'b0;
    chk("set_wins", {56'h0, status_o}, 64'h01);
    wr(8'h09, 8'h01);
    chk("held_clr", {56'h0, status_o}, 64'h0);
    idle(2);
    chk("held_noset", {56'h0, status_o}, 64'h0);

    // Unmasked flag: readable, no read side-effect, no interrupt
    event_i = 8'h03;
    idle(1);
    rd("flags_read", 8'h09, 8'h02);
    idle(1);
    chk("flags_kept", {56'h0, status_o}, 64'h02);
    chk("irq_masked", {63'h0, irq_o},    64'h0);

    // Counter is at 5; 260 more writes saturate it
    for (int i = 0; i < 260; i++) begin
      wr(8'h00, 8'(i));
    end
    chk("cfg0_last", {56'h0, cfg_o[7:0]}, 64'h03);
    rd("wrcnt_sat", 8'h0B, 8'hFF);
    wr(8'h0B, 8'h55);
    rd("wrcnt_clr", 8'h0B, 8'h00);
    wr(8'h0C, 8'h77);
    rd("id_ro",     8'h0C, 8'hA5);
    rd("wrcnt_id",  8'h0B, 8'h01);
    wr(8'h20, 8'hFF);
    rd("unmapped",  8'h20, 8'h00);
    rd("wrcnt_unm", 8'h0B, 8'h02);

    // Status synchroniser: visible on rdata within three cycles
    addr     = 8'h08;
    status_i = 8'h3C;
    idle(2);
    chk("status_early", {56'h0, rdata}, 64'h0);
    idle(1);
    chk("status_sync",  {56'h0, rdata}, 64'h3C);

    // Mid-sequence reset with the interrupt active
    wr(8'h0A, 8'hFF);
    idle(1);
    chk("irq_pre_rst", {63'h0, irq_o}, 64'h1);
    #2;
    rst_n = 1'b0;
    addr  = 8'h01;
    wdata = 8'hAA;
    we    = 1'b1;
    #1;
    chk("mid_cfg",    cfg_o,             64'h0);
    chk("mid_rdata",  {56'h0, rdata},    64'h0);
    chk("mid_irq",    {63'h0, irq_o},    64'h0);
    chk("mid_status", {56'h0, status_o}, 64'h0);
    @(negedge clk);
    we    = 1'b0;
    rst_n = 1'b1;
    idle(1);
    chk("post_cfg", cfg_o, 64'h0);
    rd("post_wrcnt", 8'h0B, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
